// File: rtl/brew_sequencer.sv
`timescale 1ns/1ps
// brew_sequencer: drink recipe sequencer driving valves through timed water/coffee/milk/choc phases
module brew_sequencer (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       brew,
    input  logic       cancel,
    input  logic [1:0] recipe,
    input  logic       t_expired,
    input  logic       timer_on,
    output logic       start_timer,
    output logic [1:0] value,
    output logic       valve_water,
    output logic       valve_coffee,
    output logic       valve_milk,
    output logic       valve_choc,
    output logic [1:0] phase,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       fault
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE, ABORT, FAULT} state_t;
    state_t     state, state_nx;
    logic [1:0] phase_nx, rec, rec_nx, gap, gap_nx, dur;
    logic [2:0] wd, wd_nx;
    logic [7:0] tbl;
    logic       brew_q;
    // duration lookup, packed per recipe as {choc, milk, coffee, water}
    always_comb begin
        tbl = rec == 2'd0 ? 8'b00_00_11_01 :
              rec == 2'd1 ? 8'b00_00_10_11 :
              rec == 2'd2 ? 8'b00_11_10_01 : 8'b01_10_10_01;
        dur = tbl[{phase, 1'b0} +: 2];
    end
    // state and counters; edge history starts high so a brew held through reset is not an edge
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            phase  <= 2'd0;
            rec    <= 2'd0;
            gap    <= 2'd0;
            wd     <= 3'd0;
            brew_q <= 1'b1;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            rec    <= rec_nx;
            gap    <= gap_nx;
            wd     <= wd_nx;
            brew_q <= brew;
        end
    end
    // next state; watchdog value 4 means the timer proved alive in this RUN
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        rec_nx   = rec;
        gap_nx   = gap;
        wd_nx    = wd;
        case (state)
            IDLE: if (!cancel && brew && !brew_q) begin
                state_nx = LOAD;
                rec_nx   = recipe;
                phase_nx = 2'd0;
            end
            LOAD: if (cancel) begin
                state_nx = ABORT;
                gap_nx   = 2'd0;
            end else if (dur != 2'd0) begin
                state_nx = RUN;
                wd_nx    = 3'd0;
            end else if (phase == 2'd3) state_nx = DONE;
            else phase_nx = phase + 2'd1;
            RUN: if (cancel) begin
                state_nx = ABORT;
                gap_nx   = 2'd0;
            end else if (t_expired) begin
                state_nx = GAP;
                gap_nx   = 2'd0;
            end else if (timer_on) wd_nx = 3'd4;
            else if (wd == 3'd3) state_nx = FAULT;
            else if (wd < 3'd3) wd_nx = wd + 3'd1;
            GAP: if (cancel) begin
                state_nx = ABORT;
                gap_nx   = 2'd0;
            end else if (gap == 2'd1) begin
                state_nx = phase == 2'd3 ? DONE : LOAD;
                phase_nx = phase == 2'd3 ? phase : phase + 2'd1;
            end else gap_nx = gap + 2'd1;
            DONE: state_nx = IDLE;
            ABORT: if (gap == 2'd2) state_nx = IDLE;
            else gap_nx = gap + 2'd1;
            FAULT: if (cancel) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // outputs decoded purely from registered state, phase and latched recipe
    always_comb begin
        start_timer  = state == RUN;
        value        = (state == LOAD || state == RUN) ? dur : 2'd0;
        valve_water  = start_timer && phase == 2'd0;
        valve_coffee = start_timer && phase == 2'd1;
        valve_milk   = start_timer && phase == 2'd2;
        valve_choc   = start_timer && phase == 2'd3;
        busy         = state == LOAD || state == RUN || state == GAP || state == ABORT;
        done         = state == DONE;
        aborted      = state == ABORT && gap == 2'd0;
        fault        = state == FAULT;
    end
endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 SHALL have ports: clk_100MHz  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: brew  in  1  brew request level, already synchronized; a 0->1 transition starts a cycle.
REQ-004 SHALL have: cancel  in  1  level, already synchronized; aborts an active cycle.
REQ-005 SHALL have: recipe  in  2  drink select: 00 espresso, 01 americano, 10 cappuccino, 11 mocha.
REQ-006 SHALL have: t_expired  in  1  timer done flag; timer clears it when start_timer falls.
REQ-007 SHALL have: timer_on  in  1  timer running flag.
REQ-008 SHALL have: start_timer  out  1  timer run request; high only in RUN.
REQ-009 SHALL have: value  out  2  phase duration in seconds; stable whenever start_timer=1.
REQ-010 SHALL have: valve_water, valve_coffee, valve_milk, valve_choc  out  1 each  actuator enables.
REQ-011 SHALL have: phase  out  2  current phase: 0 water, 1 coffee, 2 milk, 3 choc.
REQ-012 SHALL have: busy  out  1, done  out  1, aborted  out  1, fault  out  1  status flags.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, GAP, DONE, ABORT, FAULT; all outputs decoded from registered state/phase/recipe only.
REQ-014 SHALL in IDLE, on a brew rising edge (brew=1, previous-cycle brew=0) with cancel=0, latch recipe, set phase=0, go to LOAD next cycle.
REQ-015 SHALL use durations water/coffee/milk/choc (seconds): 00 -> 1/3/0/0; 01 -> 3/2/0/0; 10 -> 1/2/3/0; 11 -> 1/2/2/1.
REQ-016 SHALL in LOAD drive value to the table entry for (latched recipe, phase); nonzero -> RUN next cycle; zero -> skip.
REQ-017 SHALL skip a zero phase by incrementing phase and staying in LOAD; skipping from phase 3 -> DONE; one cycle per skipped phase.
REQ-018 SHALL in RUN hold start_timer=1, value constant, and exactly the valve of the current phase high.
REQ-019 SHALL in RUN on t_expired=1 go to GAP next cycle; start_timer and valve drop in that cycle.
REQ-020 SHALL keep start_timer=0 in GAP for exactly 2 cycles, then: phase<3 -> phase+1, LOAD; phase=3 -> DONE.
REQ-021 SHALL go to FAULT if timer_on and t_expired both stay 0 for 4 consecutive RUN cycles from RUN entry.
REQ-022 SHALL in FAULT hold fault=1, all valves 0, start_timer=0; leave to IDLE only when cancel=1.
REQ-023 SHALL in DONE assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 SHALL on cancel=1 in LOAD, RUN, or GAP go to ABORT next cycle, drop valves/start_timer, and assert aborted for 1 cycle; then 2 gap cycles, then IDLE.
REQ-025 SHALL give cancel priority over t_expired in RUN and over a simultaneous brew edge in IDLE (no cycle starts).
REQ-026 SHALL ignore brew edges and recipe changes in every state except IDLE.
REQ-027 SHALL assert busy=1 in LOAD, RUN, GAP, ABORT; busy=0 in IDLE, DONE, FAULT.
REQ-028 SHALL keep the gap counter 2 bits and the watchdog counter 3 bits, both cleared on each RUN/GAP/ABORT entry.

Reset
REQ-029 SHALL on reset_n=0 immediately force IDLE, phase=0, value=0, and all outputs 0, including mid-RUN.
REQ-030 SHALL initialize the brew edge history register to 1 so a brew held high through reset release starts nothing.

Verification
REQ-031 Espresso: recipe=00, brew 0->1 -> LOAD, RUN value=1 valve_water; t_expired -> 2-cycle gap; RUN value=3 valve_coffee; t_expired -> gap, milk/choc skipped, done pulse 1 cycle, IDLE.
REQ-032 Mocha: recipe=11 -> four RUN phases, values 1,2,2,1, valves water, coffee, milk, choc in order, each separated by exactly 2 start_timer=0 cycles.
REQ-033 Cancel in RUN of phase 1 with t_expired=1 same cycle -> ABORT, aborted=1 for 1 cycle, no phase 2, IDLE after 2 cycles.
REQ-034 Dead timer: timer_on=0, t_expired=0 after RUN entry -> fault=1 on 5th cycle, valves 0; cancel=1 -> IDLE, fault=0.
REQ-035 Reset_n low mid-RUN, brew held high across release -> all outputs 0 immediately; no cycle starts until brew falls and rises again.
REQ-036 Recipe changed 10->00 during RUN -> durations stay cappuccino (1/2/3); a brew edge while busy=1 has no effect.
